// File: rtl/led_blink_multi.sv
// -----------------------------------------------------------------------------
// led_blink_multi
//   Multi-channel LED pattern generator. Each channel owns a free-running
//   counter plus a {div, mode, duty} register set. The registered LED drive is
//   computed from the channel's current counter and settings, so the output
//   lags the counter by one cycle.
//
// Modes:
//   00 off     : LED low
//   01 blink   : LED follows counter bit div (period 2^(div+1), 50% duty)
//   10 pulse   : LED high for one cycle whenever cnt[div:0] == 0
//   11 PWM     : LED high while cnt[7:0] < duty (only with LED_PWM_EN),
//                otherwise behaves as off
//
// Build option:
//   LED_PWM_EN - when defined, mode 11 is PWM and per-channel duty registers
//                exist; when undefined, duty_i is unused and mode 11 is off.
//
// Ports:
//   clk100    in   1       system clock, sole clock domain
//   rst       in   1       synchronous active-high reset (wins over writes)
//   wren_i    in   1       one-cycle configuration write strobe
//   bcast_i   in   1       write targets every channel (ch_sel_i ignored)
//   ch_sel_i  in   CH_W    target channel for a non-broadcast write
//   div_i     in   5       divider exponent (clamped to CNT_W-1 when stored)
//   mode_i    in   2       channel mode
//   duty_i    in   8       PWM duty (0..255)
//   led_o     out  NUM_CH  registered LED drive, bit c = channel c
// -----------------------------------------------------------------------------
module led_blink_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              wren_i,
  input  logic              bcast_i,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic [4:0]        div_i,
  input  logic [1:0]        mode_i,
  input  logic [7:0]        duty_i,
  output logic [NUM_CH-1:0] led_o
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  // Largest meaningful divider for this counter width. The reset divider of
  // 24 is itself clamped so narrow counters still come out of reset blinking.
  localparam logic [4:0] DIV_MAX = 5'(CNT_W - 1);
  localparam logic [4:0] DIV_RST = (CNT_W - 1 < 24) ? DIV_MAX : 5'd24;
  localparam logic [7:0] DUTY_RST = 8'd128;

  // Write data shared by every channel; divider clamped once at write time.
  logic [4:0] div_wr;
  mode_e      mode_wr;

  always_comb begin
    div_wr  = (32'(div_i) >= CNT_W) ? DIV_MAX : div_i;
    mode_wr = mode_e'(mode_i);
  end

`ifndef LED_PWM_EN
  logic unused_duty;
  assign unused_duty = ^duty_i;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       div_q;
    mode_e            mode_q;
    logic             led_q, led_d;
    logic             hit;
`ifdef LED_PWM_EN
    logic [7:0]       duty_q;
`endif

    // Out-of-range non-broadcast selects never match any channel.
    always_comb begin
      hit = wren_i && (bcast_i || (32'(ch_sel_i) == c));
    end

    always_comb begin
      cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
    end

    // Output decode from the current (pre-edge) counter and settings.
    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] pmask;

    always_comb begin
      shifted = cnt_q >> div_q;
      // Mask of bits [div:0]; a shift of CNT_W yields 0 and the subtract
      // then wraps to all-ones, which is the correct mask for div=CNT_W-1.
      pmask   = ((CNT_W'(1) << div_q) << 1) - CNT_W'(1);
      led_d   = 1'b0;
      unique case (mode_q)
        MODE_OFF:   led_d = 1'b0;
        MODE_BLINK: led_d = shifted[0];
        MODE_PULSE: led_d = ((cnt_q & pmask) == '0);
`ifdef LED_PWM_EN
        MODE_PWM:   led_d = (cnt_q[7:0] < duty_q);
`else
        MODE_PWM:   led_d = 1'b0;
`endif
        default:    led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk100) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        mode_q <= MODE_BLINK;
        led_q  <= 1'b0;
`ifdef LED_PWM_EN
        duty_q <= DUTY_RST;
`endif
      end else begin
        cnt_q <= cnt_d;
        led_q <= led_d;
        if (hit) begin
          div_q  <= div_wr;
          mode_q <= mode_wr;
`ifdef LED_PWM_EN
          duty_q <= duty_i;
`endif
        end
      end
    end

    assign led_o[c] = led_q;
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// -----------------------------------------------------------------------------
// tb_led_blink_multi
//   Self-checking bench for led_blink_multi (NUM_CH=3, CNT_W=8). A behavioural
//   model tracks each channel's phase as an integer and derives the expected
//   LED level arithmetically; directed scenarios are followed by randomized
//   writes and resets. Define LED_PWM_EN for both files to cover PWM mode.
// -----------------------------------------------------------------------------
module tb_led_blink_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk100 = 1'b0;
  logic              rst;
  logic              wren_i;
  logic              bcast_i;
  logic [CH_W-1:0]   ch_sel_i;
  logic [4:0]        div_i;
  logic [1:0]        mode_i;
  logic [7:0]        duty_i;
  logic [NUM_CH-1:0] led_o;

  led_blink_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .wren_i   (wren_i),
    .bcast_i  (bcast_i),
    .ch_sel_i (ch_sel_i),
    .div_i    (div_i),
    .mode_i   (mode_i),
    .duty_i   (duty_i),
    .led_o    (led_o)
  );

  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Model: cycles elapsed since the channel's phase origin, plus settings.
  int m_cnt  [NUM_CH];
  int m_div  [NUM_CH];
  int m_mode [NUM_CH];
  int m_duty [NUM_CH];
  logic [NUM_CH-1:0] m_led;

  function automatic logic model_level(int c);
    int t;
    t = m_cnt[c];
    case (m_mode[c])
      1: return ((t / (1 << m_div[c])) % 2) == 1;
      2: return (t % (1 << (m_div[c] + 1))) == 0;
`ifdef LED_PWM_EN
      3: return (t % 256) < m_duty[c];
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c]  = 0;
        m_div[c]  = (CNT_W - 1 < 24) ? CNT_W - 1 : 24;
        m_mode[c] = 1;
        m_duty[c] = 128;
      end
      m_led = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) m_led[c] = model_level(c);
      for (int c = 0; c < NUM_CH; c++) begin
        if (wren_i && (bcast_i || int'(ch_sel_i) == c)) begin
          m_div[c]  = (int'(div_i) >= CNT_W) ? CNT_W - 1 : int'(div_i);
          m_mode[c] = int'(mode_i);
          m_duty[c] = int'(duty_i);
          m_cnt[c]  = 0;
        end else begin
          m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
        end
      end
    end
  endtask

  // One clock: model advances on the edge, DUT sampled 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk100);
    model_step();
    #1;
    check_eq(tag, 16'(led_o), 16'(m_led));
  endtask

  task automatic idle(input string tag, input int n);
    wren_i = 1'b0;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic wr(input string tag, input logic b, input int ch, input int dv,
                    input int md, input int dt);
    wren_i   = 1'b1;
    bcast_i  = b;
    ch_sel_i = CH_W'(ch);
    div_i    = 5'(dv);
    mode_i   = 2'(md);
    duty_i   = 8'(dt);
    cycle(tag);
    wren_i   = 1'b0;
    bcast_i  = 1'($urandom);
    ch_sel_i = CH_W'($urandom);
    div_i    = 5'($urandom);
    mode_i   = 2'($urandom);
    duty_i   = 8'($urandom);
  endtask

  initial begin
    // Reset held three cycles with a colliding write that must be discarded.
    rst = 1'b1; wren_i = 1'b1; bcast_i = 1'b1; ch_sel_i = '0;
    div_i = 5'd0; mode_i = 2'b10; duty_i = 8'd7;
    for (int i = 0; i < 3; i++) cycle("reset_hold");
    rst = 1'b0;
    idle("reset_blink", 300);

    wr("wr_ch1_blink", 1'b0, 1, 3, 1, 0);
    idle("ch1_blink", 40);
    wr("wr_ch2_pulse", 1'b0, 2, 2, 2, 0);
    idle("ch2_pulse", 40);
    wr("wr_bcast_div0", 1'b1, 0, 0, 1, 0);
    idle("bcast_toggle", 10);
    wr("wr_ch0_off", 1'b0, 0, 0, 0, 0);
    idle("ch0_off", 10);
    wr("wr_div_clamp", 1'b0, 1, 31, 1, 0);
    idle("div_clamp", 600);
    wr("wr_out_of_range", 1'b0, 3, 0, 0, 0);
    idle("out_of_range", 20);
    wr("wr_mode3_d64", 1'b0, 2, 4, 3, 64);
    idle("mode3_d64", 300);
    wr("wr_mode3_d0", 1'b0, 2, 4, 3, 0);
    idle("mode3_d0", 300);
    wr("wr_mode3_d255", 1'b1, 0, 1, 3, 255);
    idle("mode3_d255", 300);

    // Reset colliding with a write, then randomized traffic.
    rst = 1'b1; wren_i = 1'b1; bcast_i = 1'b1; div_i = 5'd1; mode_i = 2'b11;
    cycle("rst_vs_wr");
    rst = 1'b0; wren_i = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      rst      = ($urandom_range(0, 999) == 0);
      wren_i   = ($urandom_range(0, 15) == 0);
      bcast_i  = ($urandom_range(0, 3) == 0);
      ch_sel_i = CH_W'($urandom);
      div_i    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
      mode_i   = 2'($urandom);
      duty_i   = 8'($urandom);
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_blink_multi.md
LED_BLINK_MULTI -- requirements
Module: led_blink_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 32, per-channel free-running counter width (8..32).
REQ-003 Parameter CH_W, default 2, channel-select width; SHALL equal max(1, clog2(NUM_CH)).
REQ-004 clk100  input  1  system clock, 100 MHz; sole clock domain.
REQ-005 rst  input  1  reset, synchronous to clk100, active-high.
REQ-006 wren_i  input  1  config write strobe, one-cycle, sampled on rising edge of clk100.
REQ-007 bcast_i  input  1  when high with wren_i, write targets all channels; ch_sel_i ignored.
REQ-008 ch_sel_i  input  CH_W  target channel for a non-broadcast write.
REQ-009 div_i  input  5  divider exponent: selects counter bit div.
REQ-010 mode_i  input  2  channel mode: 00 off, 01 blink, 10 pulse, 11 PWM (PWM only with LED_PWM_EN).
REQ-011 duty_i  input  8  PWM duty (0..255); always present, ignored without LED_PWM_EN.
REQ-012 led_o  output  NUM_CH  registered LED drive, bit c = channel c.

Function
REQ-013 Each channel SHALL hold a register set {div, mode, duty} and a CNT_W-bit counter incrementing by 1 every cycle, wrapping from all-ones to 0.
REQ-014 Write: on wren_i=1, addressed channel(s) SHALL load div_i/mode_i/duty_i and clear their counter to 0 in the same edge; new settings govern led_o from the next edge.
REQ-015 Non-broadcast write with ch_sel_i >= NUM_CH SHALL be ignored: no register, counter or output change.
REQ-016 Broadcast write SHALL load all channels and zero all counters on the same edge (phase alignment).
REQ-017 Stored div >= CNT_W SHALL be clamped to CNT_W-1 at write time.
REQ-018 led_o[c] SHALL be registered, computed from channel c's current counter and settings (1-cycle latency).
REQ-019 Off: led_o[c] <= 0.
REQ-020 Blink: led_o[c] <= cnt[div]; period 2^(div+1) cycles, 50% duty.
REQ-021 Pulse: led_o[c] <= 1 iff cnt[div:0] == 0; one-cycle high every 2^(div+1) cycles.
REQ-022 Channels not addressed by a write SHALL continue counting and driving without disturbance.
REQ-023 wren_i=0 SHALL make bcast_i, ch_sel_i, div_i, mode_i, duty_i don't-care.

Reset
REQ-024 While rst=1 at an edge: all counters 0, div=24, mode=01 (blink), duty=128, led_o=0.
REQ-025 rst SHALL take priority over a simultaneous wren_i; the write is discarded.
REQ-026 After rst deasserts, all channels blink in phase; led_o[c] first rises at edge 2^24+1 after release.

Configuration
REQ-027 Macro LED_PWM_EN: when defined, mode 11 SHALL give led_o[c] <= (cnt[7:0] < duty); duty 0 = always low, 255 = high 255 of 256 cycles; period 256 cycles independent of div.
REQ-028 Without LED_PWM_EN, mode 11 SHALL behave as off, duty registers SHALL not be implemented, duty_i SHALL be unused.

Verification
REQ-029 Reset, NUM_CH=4, CNT_W=32: hold rst 3 cycles -> led_o=0000 during and after; all bits rise together 2^24+1 cycles after release.
REQ-030 Write ch 1 div=3 mode=01 -> led_o[1] low 8 cycles then high 8, repeating, first rise 9 cycles after write edge; other channels unchanged.
REQ-031 Write ch 2 div=2 mode=10 -> led_o[2] high exactly 1 cycle in every 8, first high on the edge after the write edge.
REQ-032 Broadcast div=0 mode=01 -> all led_o bits toggle every cycle, in phase; then write ch_sel=3 mode=00 -> led_o[3]=0 from next edge.
REQ-033 CNT_W=8: write div=31 -> stored div=7, blink period 256; write with ch_sel_i=3 and NUM_CH=3 -> no change anywhere.
REQ-034 LED_PWM_EN defined: mode=11 duty=64 -> led_o high 64 of every 256 cycles; duty=0 -> constant 0; rst asserted with wren_i same edge -> reset values win.
